// File: rtl/mem_word_sequencer.sv
// mem_word_sequencer
// Performs one 16-bit word read or write as two byte accesses (A, then A+1)
// to an 8-bit synchronous memory. Read words are reassembled into rd_data
// and held there until the next read completes.
//
// Handshake: start is sampled only while busy=0. The accepting edge latches
// wr_en/addr/wr_data and raises busy. done pulses for exactly one cycle in
// the first idle cycle after the transaction. start may be high in that done
// cycle to begin the next transaction back-to-back. There is no queueing:
// start while busy=1 is ignored.
//
// Every output comes from a register or from the state register. There is
// no combinational path from inputs to outputs.

module mem_word_sequencer #(
    parameter int unsigned WAIT_CYCLES   = 0,    // extra hold cycles per byte access (0..15)
    parameter bit          LITTLE_ENDIAN = 1'b1  // 1: byte at A is the low byte
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        wr_en,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    input  logic [7:0]  mem_rd_data,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wr_data,
    output logic        mem_cs,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic [15:0] rd_data,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Final value of the per-access wait counter.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        wr_l;     // latched direction
    logic [15:0] addr_l;   // latched base address
    logic [7:0]  wr_b1_l;  // latched second write byte (A+1)
    logic [7:0]  rd_b0;    // first read byte (from A)

    assign fsm_state = state;

    // Sequencer: state, wait counter, latched request and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            wr_l        <= 1'b0;
            addr_l      <= 16'd0;
            wr_b1_l     <= 8'd0;
            rd_b0       <= 8'd0;
            mem_address <= 16'd0;
            mem_wr_data <= 8'd0;
            mem_cs      <= 1'b0;
            mem_wr      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_data     <= 16'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        wr_l        <= wr_en;
                        addr_l      <= addr;
                        wr_b1_l     <= LITTLE_ENDIAN ? wr_data[15:8] : wr_data[7:0];
                        mem_address <= addr;
                        mem_wr_data <= LITTLE_ENDIAN ? wr_data[7:0] : wr_data[15:8];
                        mem_cs      <= 1'b1;
                        mem_wr      <= wr_en;
                        busy        <= 1'b1;
                        wait_cnt    <= 4'd0;
                        state       <= S_ACC0;
                    end
                end
                S_ACC0: begin
                    if (wait_cnt == WAIT_LAST) begin
                        // The second address wraps at 16 bits.
                        mem_address <= addr_l + 16'd1;
                        mem_wr_data <= wr_b1_l;
                        wait_cnt    <= 4'd0;
                        state       <= S_ACC1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ACC1: begin
                    // The memory returns byte A during the first ACC1 cycle.
                    if (wait_cnt == 4'd0 && !wr_l) begin
                        rd_b0 <= mem_rd_data;
                    end
                    if (wait_cnt == WAIT_LAST) begin
                        mem_cs   <= 1'b0;
                        mem_wr   <= 1'b0;
                        wait_cnt <= 4'd0;
                        state    <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_FIN: begin
                    // Byte A+1 is on mem_rd_data now. Writes leave rd_data alone.
                    if (!wr_l) begin
                        rd_data <= LITTLE_ENDIAN ? {mem_rd_data, rd_b0}
                                                 : {rd_b0, mem_rd_data};
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
